// File: rtl/lite16_pkg.sv
// Shared constants for the LITE-16 control path: sequencer state
// encoding, the HALT opcode and the datapath select encodings.
package lite16_pkg;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_HALT   = 3'd4;
    localparam logic [2:0] ST_FAULT  = 3'd5;

    localparam logic [3:0] HALT_OP = 4'b1111;

    localparam logic ADDR_PC = 1'b0;
    localparam logic ADDR_EA = 1'b1;

    localparam logic WB_ALU = 1'b0;
    localparam logic WB_MEM = 1'b1;

    // States that drive a memory request
    function automatic logic is_mem_state(input logic [2:0] s);
        return (s == ST_FETCH) || (s == ST_MEM);
    endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Counts consecutive memory wait cycles and flags expiry.
// Ports: clk, rst (sync, high), waiting, clear -> expired.
module mem_watchdog #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic waiting,
    input  logic clear,
    output logic expired
);

    localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    logic [CW-1:0] count;

    // Expiry is flagged during the MEM_TIMEOUT-th consecutive waiting
    // cycle, so the caller can leave for FAULT at the end of it.
    assign expired = (MEM_TIMEOUT != 0) && waiting &&
                     (count == CW'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (waiting) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM sequencer for LITE-16.
// Ports: clk, rst, opcode, decode lines, cond_true, mem_ready in;
//        memory handshake, datapath enables, retire/retired,
//        halted, fault out.
module cpu_sequencer
    import lite16_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       opcode,
    input  logic             ri,
    input  logic             cmp,
    input  logic             mem,
    input  logic             ld,
    input  logic             st,
    input  logic             jmp,
    input  logic             fn,
    input  logic             cond_true,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             ir_load,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             alu_en,
    output logic             reg_we,
    output logic             wb_sel,
    output logic             flags_we,
    output logic             retire,
    output logic [CNT_W-1:0] retired,
    output logic             halted,
    output logic             fault
);

    logic [2:0] state;
    logic [2:0] state_next;
    logic       expired;
    logic       waiting;
    logic       wd_clear;
    logic       live;

    // Operand select is purely a datapath concern
    logic unused_ri;
    assign unused_ri = ri;

    assign waiting  = mem_req & ~mem_ready;
    assign wd_clear = mem_ready | (state_next != state);

    mem_watchdog #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .waiting(waiting),
        .clear  (wd_clear),
        .expired(expired)
    );

    always_comb begin
        state_next = state;
        case (state)
            ST_FETCH: begin
                if (mem_ready)    state_next = ST_DECODE;
                else if (expired) state_next = ST_FAULT;
            end
            ST_DECODE: begin
                if (opcode == HALT_OP) state_next = ST_HALT;
                else if (mem)          state_next = ST_MEM;
                else                   state_next = ST_EXEC;
            end
            ST_EXEC: state_next = ST_FETCH;
            ST_MEM: begin
                if (mem_ready)    state_next = ST_FETCH;
                else if (expired) state_next = ST_FAULT;
            end
            ST_HALT:  state_next = ST_HALT;
            ST_FAULT: state_next = ST_FAULT;
            default:  state_next = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_FETCH;
            retired <= '0;
        end else begin
            state <= state_next;
            if (retire) retired <= retired + CNT_W'(1);
        end
    end

    // Moore outputs
    assign mem_req  = is_mem_state(state);
    assign mem_we   = (state == ST_MEM) & st;
    assign addr_sel = (state == ST_MEM) ? ADDR_EA : ADDR_PC;
    assign alu_en   = (state == ST_EXEC) | (state == ST_MEM);
    assign wb_sel   = (state == ST_MEM) ? WB_MEM : WB_ALU;
    assign halted   = (state == ST_HALT);
    assign fault    = (state == ST_FAULT);

    // Mealy strobes are suppressed in a reset cycle so an abandoned
    // access never updates architectural state.
    assign live     = ~rst;
    assign ir_load  = live & (state == ST_FETCH) & mem_ready;
    assign pc_inc   = live & (state == ST_FETCH) & mem_ready;
    assign pc_load  = live & (state == ST_EXEC) & jmp & cond_true;
    assign flags_we = live & (state == ST_EXEC) & (cmp | fn);
    assign reg_we   = live & (((state == ST_EXEC) & fn & ~cmp & ~jmp) |
                              ((state == ST_MEM) & mem_ready & ld));
    assign retire   = live & ((state == ST_EXEC) |
                              ((state == ST_MEM) & mem_ready));

endmodule
